cfi_marker_checker: RTL and testbench
=====================================

Name: cfi_marker_checker

Overview:
- Commit-stage control-flow-integrity monitor for the Ariane core, generalised to NR_COMMIT_PORTS commit ports.
- Checks that every committed call is immediately followed in commit order by a call-marker NOP, and every committed return by a return-marker NOP, even when the pair spans cycles.
- Tracks call depth, raising an exception on return-underflow and flagging overflow.
- Sits beside the commit stage; its exception_o is merged into the commit exception path.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit slots checked per cycle (1..4).
- MARKER_OP, ariane_pkg::ADD, fu_op of marker NOPs.
- MARKER_RD, 5'd0, rd of marker NOPs.
- MARKER_RS1, 5'd0, rs1 of marker NOPs.
- IMM_RET, 5'h1, result[4:0] identifying a return marker.
- IMM_CALL, 5'h2, result[4:0] identifying a call marker.
- DEPTH_W, 6, call-depth counter width; max depth 2^DEPTH_W-1.
- CNT_W, 16, violation counter width.
- VIOL_CAUSE, riscv::INSTR_ADDR_MISALIGNED, cause reported on violation.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  pipeline flush; drops pending marker expectation.
- csr_en_i  in  1  enables exception reporting; tracking always runs.
- commit_ack_i  in  NR_COMMIT_PORTS  slot n commits this cycle.
- commit_instr_i  in  scoreboard_entry_t[NR_COMMIT_PORTS]  instructions in slots.
- exception_o  out  exception_t  registered violation exception.
- depth_o  out  DEPTH_W  current call depth.
- overflow_o  out  1  sticky depth overflow.
- violation_cnt_o  out  CNT_W  saturating violation count.
- leds_o  out  4  debug toggles.

Behaviour:
- Reset (rst_i=1 at clk edge): pending=NONE, depth_o=0, overflow_o=0, violation_cnt_o=0, exception_o.valid=0, cause=0, tval=0, leds_o=0.
- Classification: ret = op JALR, rd=0, rs1=1. call = rd=1 (or rd=5), op JAL or JALR. call-marker / ret-marker = op MARKER_OP, rd MARKER_RD, rs1 MARKER_RS1, result[4:0] = IMM_CALL / IMM_RET.
- Slots are evaluated combinationally in order 0..N-1. A slot is "committed" if its ack is high. A pending state {NONE, WANT_CALL, WANT_RET} plus pending_pc is threaded through the slots and registered at the end of the cycle.
- For each committed slot, in order:
  - If pending≠NONE:
    - If the slot has ex.valid=1, clear pending with no violation (trap path).
    - Else if the marker matches the pending type, clear pending and toggle the LED.
    - Else raise a violation with tval=pending_pc, then clear pending.
  - Then, if ex.valid=0 and the slot was not consumed as a marker:
    - call: set pending=WANT_CALL, pending_pc=pc; depth+1, saturating at max (sets overflow_o, no exception).
    - ret: set pending=WANT_RET, pending_pc=pc; if depth=0, raise an underflow violation with tval=pc, else depth-1.
- A marker with pending=NONE is ignored. A call/ret that itself satisfies a pending check cannot occur: a call/ret is never a marker, so it raises the violation for the prior pending, then becomes the new pending.
- Non-acked slots are skipped; pending carries across any number of idle cycles.
- flush_i=1: registered pending forced to NONE at the edge; the current-cycle evaluation still completes. depth_o is unchanged.
- Multiple violations in one cycle: exception_o reports the first in slot order; violation_cnt_o adds the count of all violations, saturating at all-ones.
- exception_o latency is 1 cycle:
  - valid=1 for exactly one cycle after a violation cycle, only if csr_en_i=1 that cycle; cause=VIOL_CAUSE, tval=offending pc zero-extended.
  - Otherwise valid=0, cause=0; tval holds its last value.
- leds_o:
  - [0] toggles on each call-marker match.
  - [1] toggles on each ret-marker match.
  - [2] toggles on each cycle with ≥1 violation.
  - [3] = overflow_o.
- Reset mid-operation clears pending; no exception is issued for it.

Test Plan:
- Call at pc 0x8000_0100 in slot0, call-marker in slot1, same cycle → no exception; depth_o=1; leds_o[0]=1.
- Ret in slot1 at cycle t, ret-marker in slot0 at t+3 (idle acks between) with depth 1 → no exception; depth_o=0.
- Call at pc 0x200 in slot0, plain ADDI in slot1, csr_en_i=1 → at t+1 exception_o.valid=1, cause=VIOL_CAUSE, tval=0x200; violation_cnt_o=1; valid=0 at t+2.
- Ret at pc 0x300 with depth 0, csr_en_i=0 → no exception_o; violation_cnt_o=1; depth_o stays 0; pending=WANT_RET.
- Call committed, flush_i=1 same cycle, next commit is ADDI → no violation; depth_o=1.
- DEPTH_W=2: four calls each followed by a marker → depth_o=3, overflow_o=1, leds_o[3]=1, no exception; then rst_i=1 → all outputs 0.

Source files
------------

// File: rtl/cfi_marker_checker.sv
// Commit-stage control-flow-integrity monitor.
// Every committed call must be followed, in commit order, by a call-marker
// NOP and every committed return by a return-marker NOP, even when the pair
// spans cycles. Also tracks call depth, flags overflow and reports underflow.

package cfi_marker_pkg;
  localparam int XLEN = 64;
  localparam int VLEN = 39;

  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = 64'd0;

  typedef enum logic [6:0] {
    ADD  = 7'd0,
    SUB  = 7'd1,
    ANDL = 7'd2,
    ORL  = 7'd3,
    XORL = 7'd4,
    SLTS = 7'd5,
    JAL  = 7'd6,
    JALR = 7'd7,
    LD   = 7'd8,
    SD   = 7'd9
  } fu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_op_t          op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    exception_t      ex;
  } scoreboard_entry_t;
endpackage

module cfi_marker_checker
  import cfi_marker_pkg::*;
#(
  parameter int unsigned      NR_COMMIT_PORTS = 2,
  parameter fu_op_t           MARKER_OP       = ADD,
  parameter logic [4:0]       MARKER_RD       = 5'd0,
  parameter logic [4:0]       MARKER_RS1      = 5'd0,
  parameter logic [4:0]       IMM_RET         = 5'h1,
  parameter logic [4:0]       IMM_CALL        = 5'h2,
  parameter int unsigned      DEPTH_W         = 6,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [XLEN-1:0]  VIOL_CAUSE      = INSTR_ADDR_MISALIGNED
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       csr_en_i,
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  input  scoreboard_entry_t          commit_instr_i [NR_COMMIT_PORTS],
  output exception_t                 exception_o,
  output logic [DEPTH_W-1:0]         depth_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           violation_cnt_o,
  output logic [3:0]                 leds_o
);

  // Each slot can produce at most two violations: a missing marker for the
  // previous pending entry plus a return underflow of its own.
  localparam int unsigned VCNT_W = $clog2(2 * NR_COMMIT_PORTS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_CALL = 2'd1,
    PEND_RET  = 2'd2
  } pend_e;

  // Registered state
  pend_e               pend_reg, pend_next;
  logic [VLEN-1:0]     pend_pc_reg, pend_pc_next;
  logic [DEPTH_W-1:0]  depth_reg, depth_next;
  logic                ovf_reg, ovf_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  exception_t          exc_reg, exc_next;
  logic [2:0]          led_reg, led_next;

  // Per-slot classification
  logic [NR_COMMIT_PORTS-1:0] is_call, is_ret, is_cmark, is_rmark, is_exc;
  logic [VLEN-1:0]            slot_pc [NR_COMMIT_PORTS];

  // Combinational working values threaded through the slots
  pend_e               pend_w;
  logic [VLEN-1:0]     pend_pc_w;
  logic                consumed;
  logic [1:0]          marker_tog;
  logic [VCNT_W-1:0]   viol_n;
  logic [VLEN-1:0]     viol_pc;
  logic                any_viol;
  logic                report;
  logic [CNT_W:0]      cnt_sum;

  for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_class
    scoreboard_entry_t e;
    logic              is_marker;
    logic              unused_bits;

    assign e         = commit_instr_i[gi];
    assign is_marker = (e.op == MARKER_OP) && (e.rd == MARKER_RD) && (e.rs1 == MARKER_RS1);
    assign is_ret[gi]   = (e.op == JALR) && (e.rd == 5'd0) && (e.rs1 == 5'd1);
    assign is_call[gi]  = ((e.rd == 5'd1) || (e.rd == 5'd5)) && ((e.op == JAL) || (e.op == JALR));
    assign is_cmark[gi] = is_marker && (e.result[4:0] == IMM_CALL);
    assign is_rmark[gi] = is_marker && (e.result[4:0] == IMM_RET);
    assign is_exc[gi]   = e.ex.valid;
    assign slot_pc[gi]  = e.pc;
    // Fields of the entry this monitor never looks at
    assign unused_bits  = ^{e.result[XLEN-1:5], e.ex.cause, e.ex.tval};
  end

  // Walk the committed slots in order and compute all next-state values
  always_comb begin
    pend_w     = pend_reg;
    pend_pc_w  = pend_pc_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    consumed   = 1'b0;
    marker_tog = 2'b00;
    viol_n     = '0;
    viol_pc    = '0;

    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      consumed = 1'b0;
      if (commit_ack_i[i]) begin
        // Resolve the outstanding marker expectation first
        if (pend_w != PEND_NONE) begin
          if (is_exc[i]) begin
            pend_w = PEND_NONE;
          end else if ((pend_w == PEND_CALL) && is_cmark[i]) begin
            pend_w        = PEND_NONE;
            consumed      = 1'b1;
            marker_tog[0] = ~marker_tog[0];
          end else if ((pend_w == PEND_RET) && is_rmark[i]) begin
            pend_w        = PEND_NONE;
            consumed      = 1'b1;
            marker_tog[1] = ~marker_tog[1];
          end else begin
            if (viol_n == '0) viol_pc = pend_pc_w;
            viol_n = viol_n + VCNT_W'(1);
            pend_w = PEND_NONE;
          end
        end
        // A trapping or marker slot never opens a new expectation
        if (!is_exc[i] && !consumed) begin
          if (is_call[i]) begin
            pend_w    = PEND_CALL;
            pend_pc_w = slot_pc[i];
            if (depth_next == DEPTH_MAX) ovf_next = 1'b1;
            else depth_next = depth_next + DEPTH_W'(1);
          end else if (is_ret[i]) begin
            pend_w    = PEND_RET;
            pend_pc_w = slot_pc[i];
            if (depth_next == '0) begin
              if (viol_n == '0) viol_pc = slot_pc[i];
              viol_n = viol_n + VCNT_W'(1);
            end else begin
              depth_next = depth_next - DEPTH_W'(1);
            end
          end
        end
      end
    end

    any_viol = (viol_n != '0);
    report   = any_viol && csr_en_i;

    // Flush only drops the expectation carried into the next cycle
    pend_next    = flush_i ? PEND_NONE : pend_w;
    pend_pc_next = pend_pc_w;

    cnt_sum  = {1'b0, cnt_reg} + (CNT_W + 1)'(viol_n);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    exc_next.valid = report;
    exc_next.cause = report ? VIOL_CAUSE : '0;
    exc_next.tval  = report ? XLEN'(viol_pc) : exc_reg.tval;

    led_next = led_reg ^ {any_viol, marker_tog};
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_reg    <= PEND_NONE;
      pend_pc_reg <= '0;
      depth_reg   <= '0;
      ovf_reg     <= 1'b0;
      cnt_reg     <= '0;
      exc_reg     <= '0;
      led_reg     <= '0;
    end else begin
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
      depth_reg   <= depth_next;
      ovf_reg     <= ovf_next;
      cnt_reg     <= cnt_next;
      exc_reg     <= exc_next;
      led_reg     <= led_next;
    end
  end

  assign exception_o     = exc_reg;
  assign depth_o         = depth_reg;
  assign overflow_o      = ovf_reg;
  assign violation_cnt_o = cnt_reg;
  assign leds_o          = {ovf_reg, led_reg};

endmodule

// File: tb/tb_cfi_marker_checker.sv
// Self-checking bench for cfi_marker_checker: directed scenarios plus a
// randomized run compared against a commit-stream reference model.

module tb_cfi_marker_checker;
  import cfi_marker_pkg::*;

  localparam int N  = 2;
  localparam int DW = 2;
  localparam int CW = 16;
  localparam logic [63:0] TB_CAUSE = 64'd5;
  localparam int MAX_DEPTH = (1 << DW) - 1;
  localparam int MAX_CNT   = (1 << CW) - 1;

  localparam int K_OTHER = 0;
  localparam int K_CALL  = 1;
  localparam int K_RET   = 2;
  localparam int K_CMARK = 3;
  localparam int K_RMARK = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              csr_en_i = 1'b0;
  logic [N-1:0]      commit_ack_i = '0;
  scoreboard_entry_t commit_instr_i [N];
  exception_t        exception_o;
  logic [DW-1:0]     depth_o;
  logic              overflow_o;
  logic [CW-1:0]     violation_cnt_o;
  logic [3:0]        leds_o;

  cfi_marker_checker #(
    .NR_COMMIT_PORTS(N),
    .DEPTH_W(DW),
    .CNT_W(CW),
    .VIOL_CAUSE(TB_CAUSE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .csr_en_i(csr_en_i),
    .commit_ack_i(commit_ack_i),
    .commit_instr_i(commit_instr_i),
    .exception_o(exception_o),
    .depth_o(depth_o),
    .overflow_o(overflow_o),
    .violation_cnt_o(violation_cnt_o),
    .leds_o(leds_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int tx_no  = 0;

  // Reference model state (0 = nothing expected, 1 = call marker, 2 = ret marker)
  int          m_pend  = 0;
  logic [38:0] m_ppc   = '0;
  int          m_depth = 0;
  bit          m_ovf   = 1'b0;
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_cause = '0;
  logic [63:0] m_tval  = '0;
  bit [2:0]    m_led   = '0;

  function automatic scoreboard_entry_t mk(input fu_op_t op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [63:0] res,
                                           input logic [38:0] pc, input bit exc);
    scoreboard_entry_t e;
    e          = '0;
    e.op       = op;
    e.rd       = rd;
    e.rs1      = rs1;
    e.result   = res;
    e.pc       = pc;
    e.ex.valid = exc;
    e.ex.cause = exc ? 64'd2 : 64'd0;
    return e;
  endfunction

  function automatic scoreboard_entry_t mk_call(input logic [38:0] pc);
    return mk(JAL, 5'd1, 5'd0, 64'h0, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mk_ret(input logic [38:0] pc);
    return mk(JALR, 5'd0, 5'd1, 64'h0, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mk_cmark(input logic [38:0] pc);
    return mk(ADD, 5'd0, 5'd0, 64'h2, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mk_rmark(input logic [38:0] pc);
    return mk(ADD, 5'd0, 5'd0, 64'h1, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mk_addi(input logic [38:0] pc);
    return mk(ADD, 5'd5, 5'd5, 64'h1234, pc, 1'b0);
  endfunction

  // Instruction category from the encoding rules
  function automatic int kind(input scoreboard_entry_t e);
    logic [4:0] imm;
    imm = e.result[4:0];
    if (e.op == JALR && e.rd == 5'd0 && e.rs1 == 5'd1) return K_RET;
    if ((e.rd == 5'd1 || e.rd == 5'd5) && (e.op == JAL || e.op == JALR)) return K_CALL;
    if (e.op == ADD && e.rd == 5'd0 && e.rs1 == 5'd0 && imm == 5'h2) return K_CMARK;
    if (e.op == ADD && e.rd == 5'd0 && e.rs1 == 5'd0 && imm == 5'h1) return K_RMARK;
    return K_OTHER;
  endfunction

  function automatic scoreboard_entry_t rnd_instr();
    logic [38:0] pc;
    int          r;
    bit          exc;
    scoreboard_entry_t e;
    pc  = 39'({$urandom(), $urandom()}) & ~39'h3;
    r   = int'($urandom_range(0, 9));
    exc = ($urandom_range(0, 9) == 0);
    case (r)
      0, 1:    e = mk(JAL, 5'd1, 5'(($urandom_range(0, 31))), 64'h0, pc, exc);
      2:       e = mk(JALR, 5'd5, 5'(($urandom_range(0, 31))), 64'h0, pc, exc);
      3, 4:    e = mk(JALR, 5'd0, 5'd1, 64'h0, pc, exc);
      5, 6:    e = mk(ADD, 5'd0, 5'd0, 64'h2, pc, exc);
      7:       e = mk(ADD, 5'd0, 5'd0, 64'h1, pc, exc);
      8:       e = mk(ADD, 5'd0, 5'd0, 64'h3, pc, exc);
      default: e = mk(ADD, 5'd5, 5'd5, 64'h55, pc, exc);
    endcase
    return e;
  endfunction

  // Reference model: walk the committed instructions of one cycle in order
  task automatic model_cycle(input bit rst, input bit flush, input bit csr,
                             input logic [1:0] ack, input scoreboard_entry_t s0,
                             input scoreboard_entry_t s1);
    scoreboard_entry_t q[$];
    logic [38:0]       vpc[$];
    int                k;
    bit                used;
    if (rst) begin
      m_pend = 0; m_ppc = '0; m_depth = 0; m_ovf = 1'b0; m_cnt = 0;
      m_valid = 1'b0; m_cause = '0; m_tval = '0; m_led = '0;
      return;
    end
    if (ack[0]) q.push_back(s0);
    if (ack[1]) q.push_back(s1);
    foreach (q[i]) begin
      k    = kind(q[i]);
      used = 1'b0;
      if (m_pend != 0) begin
        if (q[i].ex.valid) begin
          m_pend = 0;
        end else if (m_pend == 1 && k == K_CMARK) begin
          m_led[0] = ~m_led[0]; used = 1'b1; m_pend = 0;
        end else if (m_pend == 2 && k == K_RMARK) begin
          m_led[1] = ~m_led[1]; used = 1'b1; m_pend = 0;
        end else begin
          vpc.push_back(m_ppc); m_pend = 0;
        end
      end
      if (!q[i].ex.valid && !used) begin
        if (k == K_CALL) begin
          m_pend = 1; m_ppc = q[i].pc;
          if (m_depth == MAX_DEPTH) m_ovf = 1'b1; else m_depth++;
        end else if (k == K_RET) begin
          m_pend = 2; m_ppc = q[i].pc;
          if (m_depth == 0) vpc.push_back(q[i].pc); else m_depth--;
        end
      end
    end
    if (vpc.size() > 0 && csr) begin
      m_valid = 1'b1; m_cause = TB_CAUSE; m_tval = 64'(vpc[0]);
    end else begin
      m_valid = 1'b0; m_cause = '0;
    end
    m_cnt = (m_cnt + vpc.size() > MAX_CNT) ? MAX_CNT : m_cnt + vpc.size();
    if (vpc.size() > 0) m_led[2] = ~m_led[2];
    if (flush) m_pend = 0;
  endtask

  // Apply one cycle of inputs, advance the model, sample just after the edge
  task automatic step(input bit rst, input bit flush, input bit csr, input logic [1:0] ack,
                      input scoreboard_entry_t s0, input scoreboard_entry_t s1);
    @(negedge clk_i);
    rst_i = rst; flush_i = flush; csr_en_i = csr; commit_ack_i = ack;
    commit_instr_i[0] = s0; commit_instr_i[1] = s1;
    model_cycle(rst, flush, csr, ack, s0, s1);
    @(posedge clk_i);
    #1;
    tx_no++;
    $display("tx %0d rst=%0b flush=%0b csr=%0b ack=%b exc=%0b tval=%h depth=%0d cnt=%0d leds=%b",
             tx_no, rst, flush, csr, ack, exception_o.valid, exception_o.tval, depth_o,
             violation_cnt_o, leds_o);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, mk_call(39'h999), mk_call(39'h999));
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", exception_o.valid); end
    checks++; if (exception_o.cause !== 64'd0) begin errors++; $display("FAIL reset cause: got %h want 0", exception_o.cause); end
    checks++; if (exception_o.tval !== 64'd0) begin errors++; $display("FAIL reset tval: got %h want 0", exception_o.tval); end
    checks++; if (depth_o !== 2'd0) begin errors++; $display("FAIL reset depth: got %0d want 0", depth_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow_o); end
    checks++; if (violation_cnt_o !== 16'd0) begin errors++; $display("FAIL reset cnt: got %0d want 0", violation_cnt_o); end
    checks++; if (leds_o !== 4'd0) begin errors++; $display("FAIL reset leds: got %b want 0000", leds_o); end
  endtask

  task automatic test_call_marker_same_cycle();
    step(1'b0, 1'b0, 1'b1, 2'b11, mk_call(39'h80000100), mk_cmark(39'h80000104));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL call_pair valid: got %b want 0", exception_o.valid); end
    checks++; if (depth_o !== 2'd1) begin errors++; $display("FAIL call_pair depth: got %0d want 1", depth_o); end
    checks++; if (leds_o[0] !== 1'b1) begin errors++; $display("FAIL call_pair led0: got %b want 1", leds_o[0]); end
  endtask

  task automatic test_ret_span_cycles();
    step(1'b0, 1'b0, 1'b1, 2'b11, mk_addi(39'h3fc), mk_ret(39'h400));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL ret_span t valid: got %b want 0", exception_o.valid); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b00, mk_call(39'h910), mk_ret(39'h914));
      checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL ret_span idle valid: got %b want 0", exception_o.valid); end
    end
    step(1'b0, 1'b0, 1'b1, 2'b01, mk_rmark(39'h404), mk_call(39'h408));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL ret_span end valid: got %b want 0", exception_o.valid); end
    checks++; if (depth_o !== 2'd0) begin errors++; $display("FAIL ret_span depth: got %0d want 0", depth_o); end
    checks++; if (violation_cnt_o !== 16'd0) begin errors++; $display("FAIL ret_span cnt: got %0d want 0", violation_cnt_o); end
    checks++; if (leds_o[1:0] !== 2'b11) begin errors++; $display("FAIL ret_span leds: got %b want 11", leds_o[1:0]); end
  endtask

  task automatic test_missing_marker();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2'b11, mk_call(39'h200), mk_addi(39'h204));
    checks++; if (exception_o.valid !== 1'b1) begin errors++; $display("FAIL missing valid: got %b want 1", exception_o.valid); end
    checks++; if (exception_o.cause !== TB_CAUSE) begin errors++; $display("FAIL missing cause: got %h want %h", exception_o.cause, TB_CAUSE); end
    checks++; if (exception_o.tval !== 64'h200) begin errors++; $display("FAIL missing tval: got %h want 200", exception_o.tval); end
    checks++; if (violation_cnt_o !== 16'd1) begin errors++; $display("FAIL missing cnt: got %0d want 1", violation_cnt_o); end
    checks++; if (leds_o[2] !== 1'b1) begin errors++; $display("FAIL missing led2: got %b want 1", leds_o[2]); end
    step(1'b0, 1'b0, 1'b1, 2'b00, mk_addi(39'h0), mk_addi(39'h0));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL missing t2 valid: got %b want 0", exception_o.valid); end
    checks++; if (exception_o.cause !== 64'd0) begin errors++; $display("FAIL missing t2 cause: got %h want 0", exception_o.cause); end
    checks++; if (exception_o.tval !== 64'h200) begin errors++; $display("FAIL missing t2 tval hold: got %h want 200", exception_o.tval); end
  endtask

  task automatic test_underflow_no_csr();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 2'b01, mk_ret(39'h300), mk_call(39'h304));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL underflow valid: got %b want 0", exception_o.valid); end
    checks++; if (violation_cnt_o !== 16'd1) begin errors++; $display("FAIL underflow cnt: got %0d want 1", violation_cnt_o); end
    checks++; if (depth_o !== 2'd0) begin errors++; $display("FAIL underflow depth: got %0d want 0", depth_o); end
    checks++; if (exception_o.tval !== 64'd0) begin errors++; $display("FAIL underflow tval: got %h want 0", exception_o.tval); end
    step(1'b0, 1'b0, 1'b1, 2'b01, mk_rmark(39'h304), mk_call(39'h308));
    checks++; if (violation_cnt_o !== 16'd1) begin errors++; $display("FAIL underflow pending cnt: got %0d want 1", violation_cnt_o); end
    checks++; if (leds_o[1] !== 1'b1) begin errors++; $display("FAIL underflow pending led1: got %b want 1", leds_o[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2'b01, mk_call(39'h500), mk_call(39'h504));
    step(1'b0, 1'b0, 1'b1, 2'b01, mk_addi(39'h504), mk_call(39'h508));
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL flush valid: got %b want 0", exception_o.valid); end
    checks++; if (violation_cnt_o !== 16'd0) begin errors++; $display("FAIL flush cnt: got %0d want 0", violation_cnt_o); end
    checks++; if (depth_o !== 2'd1) begin errors++; $display("FAIL flush depth: got %0d want 1", depth_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2'b10, mk_ret(39'h5fc), mk_call(39'h600));
    step(1'b0, 1'b0, 1'b1, 2'b11, mk_ret(39'h700), mk_call(39'h800));
    checks++; if (exception_o.valid !== 1'b1) begin errors++; $display("FAIL b2b valid: got %b want 1", exception_o.valid); end
    checks++; if (exception_o.tval !== 64'h600) begin errors++; $display("FAIL b2b tval: got %h want 600", exception_o.tval); end
    checks++; if (violation_cnt_o !== 16'd2) begin errors++; $display("FAIL b2b cnt: got %0d want 2", violation_cnt_o); end
    checks++; if (depth_o !== 2'd1) begin errors++; $display("FAIL b2b depth: got %0d want 1", depth_o); end
    checks++; if (leds_o[2] !== 1'b1) begin errors++; $display("FAIL b2b led2: got %b want 1", leds_o[2]); end
  endtask

  task automatic test_random();
    scoreboard_entry_t s0, s1;
    bit rst, flush, csr;
    logic [1:0] ack;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      s0    = rnd_instr();
      s1    = rnd_instr();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      csr   = ($urandom_range(0, 3) != 0);
      ack   = 2'($urandom_range(0, 3));
      step(rst, flush, csr, ack, s0, s1);
      checks++; if (exception_o.valid !== m_valid) begin errors++; $display("FAIL rnd[%0d] valid: got %b want %b", n, exception_o.valid, m_valid); end
      checks++; if (exception_o.cause !== m_cause) begin errors++; $display("FAIL rnd[%0d] cause: got %h want %h", n, exception_o.cause, m_cause); end
      checks++; if (exception_o.tval !== m_tval) begin errors++; $display("FAIL rnd[%0d] tval: got %h want %h", n, exception_o.tval, m_tval); end
      checks++; if (depth_o !== DW'(m_depth)) begin errors++; $display("FAIL rnd[%0d] depth: got %0d want %0d", n, depth_o, m_depth); end
      checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd[%0d] overflow: got %b want %b", n, overflow_o, m_ovf); end
      checks++; if (violation_cnt_o !== CW'(m_cnt)) begin errors++; $display("FAIL rnd[%0d] cnt: got %0d want %0d", n, violation_cnt_o, m_cnt); end
      checks++; if (leds_o !== {m_ovf, m_led}) begin errors++; $display("FAIL rnd[%0d] leds: got %b want %b", n, leds_o, {m_ovf, m_led}); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b11, mk_call(39'(32'h1000 + 16 * i)), mk_cmark(39'(32'h1004 + 16 * i)));
    end
    checks++; if (depth_o !== 2'd3) begin errors++; $display("FAIL ovf depth: got %0d want 3", depth_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf flag: got %b want 1", overflow_o); end
    checks++; if (leds_o[3] !== 1'b1) begin errors++; $display("FAIL ovf led3: got %b want 1", leds_o[3]); end
    checks++; if (exception_o.valid !== 1'b0) begin errors++; $display("FAIL ovf valid: got %b want 0", exception_o.valid); end
    checks++; if (violation_cnt_o !== 16'd0) begin errors++; $display("FAIL ovf cnt: got %0d want 0", violation_cnt_o); end
    do_reset();
    checks++; if (depth_o !== 2'd0) begin errors++; $display("FAIL ovf reset depth: got %0d want 0", depth_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf reset flag: got %b want 0", overflow_o); end
    checks++; if (leds_o !== 4'd0) begin errors++; $display("FAIL ovf reset leds: got %b want 0000", leds_o); end
    checks++; if (exception_o !== '0) begin errors++; $display("FAIL ovf reset exception: got %h want 0", exception_o); end
  endtask

  initial begin
    commit_instr_i[0] = '0;
    commit_instr_i[1] = '0;
    test_reset();
    test_call_marker_same_cycle();
    test_ret_span_cycles();
    test_missing_marker();
    test_underflow_no_csr();
    test_flush();
    test_back_to_back();
    test_random();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
